l2_port_arbiter: RTL and testbench

//  Round-robin arbiter sharing one L2 request port (new_l2_cache l1_* side) among NUM_PORTS L1 caches.

---
 rtl/l2_port_arbiter_pkg.sv | 18 +
 rtl/l2_port_arbiter_rr_picker.sv | 30 +++
 rtl/l2_port_arbiter.sv | 112 +++++++++++
 tb/tb_l2_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_port_arbiter_pkg.sv
// Shared definitions for the L2 port arbiter: FSM encodings and default sizes.
package l2_port_arbiter_pkg;

  // Default L1 line payload width in bits.
  localparam int L1_LINE_WIDTH = 128;

  // Default number of ISSUE cycles allowed before the watchdog flags an error.
  localparam int ARB_TIMEOUT_CYC = 1024;

  // Arbiter transaction phases.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_RESP    = 2'd2,
    ARB_HOLDOFF = 2'd3
  } arb_state_t;

endpackage

// File: rtl/l2_port_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first set request at or
// above the pointer, wrapping from N-1 back to 0.
module l2_port_arbiter_rr_picker #(
  parameter  int N     = 2,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = int'(ptr) + off;
      if (cand >= N) cand = cand - N;
      if (req[cand]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter that shares one L2 request port among several L1
// caches, serialises their line transactions, routes the response back to
// the granted requester and flags an L2 that never answers.
module l2_port_arbiter
  import l2_port_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS   = 2,
  parameter  int ADDR_W      = 32,
  parameter  int LINE_W      = L1_LINE_WIDTH,
  parameter  int TIMEOUT_CYC = ARB_TIMEOUT_CYC,
  localparam int IDX_W       = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
  input  logic [NUM_PORTS-1:0]        req_rd,
  input  logic [NUM_PORTS-1:0]        req_wr,
  output logic [LINE_W-1:0]           req_rdata,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [ADDR_W-1:0]           l2_addr,
  output logic [LINE_W-1:0]           l2_wdata,
  output logic                        l2_rd,
  output logic                        l2_wr,
  input  logic [LINE_W-1:0]           l2_rdata,
  input  logic                        l2_ready,
  output logic [IDX_W-1:0]            grant_id,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] wd_cnt;
  logic [NUM_PORTS-1:0] request;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  // A port is requesting when either of its read or write lines is high.
  always_comb begin
    request = req_rd | req_wr;
  end

  l2_port_arbiter_rr_picker #(
    .N(NUM_PORTS)
  ) u_picker (
    .req  (request),
    .ptr  (rr_ptr),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  // Transaction FSM with registered outputs, latched request and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      rr_ptr      <= '0;
      wd_cnt      <= '0;
      grant_id    <= '0;
      l2_addr     <= '0;
      l2_wdata    <= '0;
      l2_rd       <= 1'b0;
      l2_wr       <= 1'b0;
      req_rdata   <= '0;
      req_ready   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_idx;
            l2_addr  <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            l2_wdata <= req_wdata[int'(pick_idx)*LINE_W +: LINE_W];
            // A port asserting both read and write is served as a write.
            l2_wr    <= req_wr[pick_idx];
            l2_rd    <= req_rd[pick_idx] & ~req_wr[pick_idx];
            wd_cnt   <= '0;
            busy     <= 1'b1;
            state    <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (wd_cnt < CNT_W'(TIMEOUT_CYC)) wd_cnt <= wd_cnt + CNT_W'(1);
          if (wd_cnt >= CNT_W'(TIMEOUT_CYC - 1)) timeout_err <= 1'b1;
          if (l2_ready) begin
            req_rdata <= l2_rdata;
            l2_rd     <= 1'b0;
            l2_wr     <= 1'b0;
            req_ready <= NUM_PORTS'(1) << grant_id;
            rr_ptr    <= (grant_id == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_id + IDX_W'(1);
            state     <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          req_ready <= '0;
          state     <= ARB_HOLDOFF;
        end
        ARB_HOLDOFF: begin
          busy  <= 1'b0;
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// transaction-level reference model.
module tb_l2_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int LW = 64;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*LW-1:0] req_wdata = '0;
  logic [N-1:0]    req_rd = '0;
  logic [N-1:0]    req_wr = '0;
  logic [LW-1:0]   req_rdata;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   l2_addr;
  logic [LW-1:0]   l2_wdata;
  logic            l2_rd;
  logic            l2_wr;
  logic [LW-1:0]   l2_rdata = '0;
  logic            l2_ready = 1'b0;
  logic [0:0]      grant_id;
  logic            busy;
  logic            timeout_err;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  l2_port_arbiter #(
    .NUM_PORTS(N), .ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd), .req_wr(req_wr),
    .req_rdata(req_rdata), .req_ready(req_ready),
    .l2_addr(l2_addr), .l2_wdata(l2_wdata), .l2_rd(l2_rd), .l2_wr(l2_wr),
    .l2_rdata(l2_rdata), .l2_ready(l2_ready),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: owner=-1 means no transaction; phase 0 waits for L2,
  // phase 1 is the response cycle, phase 2 is the cool-down cycle.
  int            m_owner = -1;
  int            m_phase = 0;
  int            m_ptr = 0;
  int            m_wait = 0;
  int            m_grant = 0;
  bit            m_wr = 0;
  bit            m_err = 0;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0;
  logic [LW-1:0] m_rdata = '0;

  always @(posedge clk or negedge rst_n) begin : ref_model
    int found;
    if (!rst_n) begin
      m_owner <= -1; m_phase <= 0; m_ptr <= 0; m_wait <= 0; m_grant <= 0;
      m_wr <= 0; m_err <= 0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
    end else if (m_owner < 0) begin
      found = -1;
      for (int k = 0; k < N; k++)
        if (found < 0 && (req_rd[(m_ptr + k) % N] || req_wr[(m_ptr + k) % N]))
          found = (m_ptr + k) % N;
      if (found >= 0) begin
        m_owner <= found; m_grant <= found; m_wr <= req_wr[found];
        m_addr <= req_addr[found*AW +: AW]; m_wdata <= req_wdata[found*LW +: LW];
        m_phase <= 0; m_wait <= 0;
      end
    end else if (m_phase == 0) begin
      m_wait <= m_wait + 1;
      if (m_wait + 1 >= TO) m_err <= 1;
      if (l2_ready) begin
        m_rdata <= l2_rdata;
        m_phase <= 1;
        m_ptr <= (m_owner + 1) % N;
      end
    end else if (m_phase == 1) begin
      m_phase <= 2;
    end else begin
      m_owner <= -1;
    end
  end

  // Every cycle, compare all DUT outputs to the model away from the clock edge.
  always @(negedge clk) begin : compare
    logic [N-1:0] er;
    er = (m_owner >= 0 && m_phase == 1) ? (N'(1) << m_owner) : '0;
    checkOutput("req_ready", req_ready, er);
    checkOutput("req_rdata", req_rdata, m_rdata);
    checkOutput("l2_addr", l2_addr, m_addr);
    checkOutput("l2_wdata", l2_wdata, m_wdata);
    checkOutput("l2_rd", l2_rd, (m_owner >= 0 && m_phase == 0 && !m_wr));
    checkOutput("l2_wr", l2_wr, (m_owner >= 0 && m_phase == 0 && m_wr));
    checkOutput("grant_id", grant_id, m_grant);
    checkOutput("busy", busy, (m_owner >= 0));
    checkOutput("timeout_err", timeout_err, m_err);
  end

  logic [LW-1:0] lineA5 = {8{8'hA5}};
  bit            s_rd, s_wr;
  logic [AW-1:0] s_addr;
  logic [LW-1:0] s_wdata;
  bit            pend [N];
  int            l2_delay = -1;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic setReq(input int p, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
    req_rd[p] = rd;
    req_wr[p] = wr;
    req_addr[p*AW +: AW] = a;
    req_wdata[p*LW +: LW] = d;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    l2_ready = 1'b0; l2_rdata = '0;
    #1;
    checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_l2_rd", l2_rd, 0);
    checkOutput("reset_l2_wr", l2_wr, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_grant", grant_id, 0);
    checkOutput("reset_timeout", timeout_err, 0);
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic waitL2();
    int t = 0;
    while (!(l2_rd || l2_wr) && t < 50) begin
      step();
      t++;
    end
    if (!(l2_rd || l2_wr)) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL wait_l2_request: got no l2_rd/l2_wr, expected one within 50 cycles");
    end
  endtask

  // Serve one L2 transaction expected to belong to port exp_p, then drop its request.
  task automatic serve(input int exp_p, input int delay, input logic [LW-1:0] line);
    waitL2();
    s_rd = l2_rd; s_wr = l2_wr; s_addr = l2_addr; s_wdata = l2_wdata;
    checkOutput("serve_grant", grant_id, exp_p);
    repeat (delay) step();
    l2_ready = 1'b1;
    l2_rdata = line;
    step();
    l2_ready = 1'b0;
    checkOutput("serve_ready", req_ready, N'(1) << exp_p);
    req_rd[exp_p] = 1'b0;
    req_wr[exp_p] = 1'b0;
  endtask

  // Random requesters and a randomly slow L2 with occasional stray ready pulses.
  task automatic applyStimulus();
    for (int p = 0; p < N; p++) begin
      if (pend[p] && req_ready[p]) begin
        req_rd[p] = 1'b0; req_wr[p] = 1'b0; pend[p] = 0;
      end else if (!pend[p] && $urandom_range(0, 3) == 0) begin
        int op;
        op = $urandom_range(0, 2);
        setReq(p, op != 1, op != 0, $urandom, {$urandom, $urandom});
        pend[p] = 1;
      end
    end
    if (l2_ready) begin
      l2_ready = 1'b0;
    end else if (l2_rd || l2_wr) begin
      if (l2_delay < 0) l2_delay = $urandom_range(0, 4);
      if (l2_delay == 0) begin
        l2_ready = 1'b1; l2_rdata = {$urandom, $urandom}; l2_delay = -1;
      end else begin
        l2_delay--;
      end
    end else begin
      l2_delay = -1;
      l2_ready = ($urandom_range(0, 9) == 0);
      l2_rdata = {$urandom, $urandom};
    end
  endtask

  initial begin
    #1;
    // Single read from port 0.
    doReset();
    setReq(0, 1, 0, 32'h1000, '0);
    step();
    checkOutput("t1_l2_rd_after_pick", l2_rd, 1);
    checkOutput("t1_l2_addr", l2_addr, 32'h1000);
    serve(0, 4, lineA5);
    checkOutput("t1_req_rdata", req_rdata, lineA5);
    checkOutput("t1_l2_rd_dropped", l2_rd, 0);
    repeat (3) step();

    // Contention right after reset: port 0 first, then port 1's write.
    doReset();
    setReq(0, 1, 0, 32'h1000, '0);
    setReq(1, 0, 1, 32'h2000, 64'h1111_2222_3333_4444);
    step();
    serve(0, 2, 64'h0123_4567_89AB_CDEF);
    checkOutput("t2_p0_rd", s_rd, 1);
    checkOutput("t2_p0_addr", s_addr, 32'h1000);
    serve(1, 1, 64'hFEDC_BA98_7654_3210);
    checkOutput("t2_p1_wr", s_wr, 1);
    checkOutput("t2_p1_rd", s_rd, 0);
    checkOutput("t2_p1_addr", s_addr, 32'h2000);
    checkOutput("t2_p1_wdata", s_wdata, 64'h1111_2222_3333_4444);
    checkOutput("t2_rdata", req_rdata, 64'hFEDC_BA98_7654_3210);
    repeat (3) step();

    // Fairness: both ports re-request immediately; grants must alternate.
    doReset();
    setReq(0, 1, 0, 32'h100, '0);
    setReq(1, 1, 0, 32'h200, '0);
    for (int i = 0; i < 8; i++) begin
      serve(i % 2, 1, 64'(i));
      step();
      setReq(i % 2, 1, 0, 32'(32'h100 * (i % 2 + 1)), '0);
    end
    req_rd = '0;
    repeat (4) step();

    // Read and write together on port 1 is served as a write.
    doReset();
    setReq(1, 1, 1, 32'h3000, 64'hAAAA_BBBB_CCCC_DDDD);
    step();
    checkOutput("t4_l2_wr", l2_wr, 1);
    checkOutput("t4_l2_rd", l2_rd, 0);
    serve(1, 1, 64'h55);
    repeat (3) step();

    // Watchdog: withhold l2_ready for 20 cycles.
    doReset();
    setReq(0, 1, 0, 32'h4000, '0);
    step();
    for (int j = 1; j <= 20; j++) begin
      step();
      if (j == 15) checkOutput("t5_err_before", timeout_err, 0);
      if (j == 16) checkOutput("t5_err_at_16", timeout_err, 1);
    end
    serve(0, 0, 64'h77);
    repeat (3) step();
    checkOutput("t5_err_sticky", timeout_err, 1);

    // Reset during ISSUE drops the request and restores the pointer to port 0.
    doReset();
    setReq(0, 1, 0, 32'h5000, '0);
    step();
    serve(0, 0, 64'h88);
    setReq(1, 1, 0, 32'h6000, '0);
    waitL2();
    checkOutput("t6_pre_grant", grant_id, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_l2_rd", l2_rd, 0);
    checkOutput("t6_rst_ready", req_ready, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_addr", l2_addr, 0);
    checkOutput("t6_rst_rdata", req_rdata, 0);
    step();
    step();
    setReq(0, 1, 0, 32'h7000, '0);
    rst_n = 1'b1;
    serve(0, 1, 64'h99);
    serve(1, 1, 64'hAA);
    repeat (3) step();

    // Randomized traffic.
    doReset();
    for (int p = 0; p < N; p++) pend[p] = 0;
    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 1000000");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
